mojo_serial_block_in: RTL

//  Receive-side block assembler for the serial link. Collects BLOCK_BYTES consecutive bytes from
//  the UART receiver (rx_data/new_rx_data) into one wide word, then presents it with a 1-cycle strobe.

---
 rtl/mojo_serial_block_in.sv | 55 +++++
 1 files changed

// File: rtl/mojo_serial_block_in.sv
// mojo_serial_block_in: assembles BLOCK_BYTES received bytes into one block word, with inter-byte timeout
module mojo_serial_block_in #(
   parameter int BLOCK_BYTES = 4,
   parameter int TIMEOUT_CYCLES = 0,
   localparam int BLOCK_BITS = BLOCK_BYTES * 8,
   localparam int CW = $clog2(BLOCK_BYTES) + 1,
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  new_rx_data,
   input  logic                  clear,
   output logic [BLOCK_BITS-1:0] rx_block,
   output logic                  new_rx_block,
   output logic [CW-1:0]         rx_count,
   output logic                  rx_timeout
);
   typedef enum logic {IDLE, FILL} state_t;
   state_t state, state_d;
   logic [BLOCK_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0] count_d;
   logic [TW-1:0] timer, timer_d;
   logic accept, last, expire;
   // next-state: accept bytes, detect completion/timeout, clear wins over everything
   always_comb begin
      accept = new_rx_data && !clear;
      last = accept && rx_count == CW'(BLOCK_BYTES - 1);
      expire = TIMEOUT_CYCLES != 0 && state == FILL && !new_rx_data && !clear && timer == TW'(TIMEOUT_CYCLES);
      shift_d = accept ? (shift_q << 8) | BLOCK_BITS'(rx_data) : shift_q;
      state_d = (clear || last || expire) ? IDLE : accept ? FILL : state;
      count_d = (clear || last || expire) ? '0 : accept ? rx_count + CW'(1) : rx_count;
      timer_d = (state_d == FILL && !accept) ? timer + TW'(~&timer) : '0;
   end
   // state register; rx_block only loads on completion so partial data never shows
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rx_count <= '0;
         timer <= '0;
         shift_q <= '0;
         rx_block <= '0;
         new_rx_block <= 1'b0;
         rx_timeout <= 1'b0;
      end else begin
         state <= state_d;
         rx_count <= count_d;
         timer <= timer_d;
         shift_q <= shift_d;
         new_rx_block <= last;
         rx_timeout <= expire;
         if (last) rx_block <= shift_d;
      end
   end
endmodule
